combo_lock_ctrl: RTL and testbench

COMBO_LOCK_CTRL -- requirements
Module: combo_lock_ctrl

---
 rtl/combo_lock_pkg.sv | 37 +++
 rtl/lock_timer.sv | 31 +++
 rtl/combo_lock_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_combo_lock_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg: shared types and constants for the combination lock.
//   state_t    - controller state encoding (PROGRAM exists only when
//                COMBO_LOCK_REPROGRAM_EN is defined)
//   DIGIT_W    - bits per entered digit (one hex nibble)
//   TIMER_W    - width of the shared OPEN/LOCKOUT down-counter
//   DISP_OPEN  - display pattern while the lock is open
//   DISP_LOCK  - display pattern while in lockout
//   code_mask  - selects the low <len> nibbles of a 16-bit code word
package combo_lock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned TIMER_W = 32;

  localparam logic [15:0] DISP_OPEN = 16'hAAAA;
  localparam logic [15:0] DISP_LOCK = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT
`ifdef COMBO_LOCK_REPROGRAM_EN
    , PROGRAM
`endif
  } state_t;

  function automatic logic [15:0] code_mask(input int unsigned len);
    logic [15:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < len) m[i*DIGIT_W +: DIGIT_W] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter shared by the OPEN and LOCKOUT states.
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (count cleared to zero)
//   load       - load load_value on the next edge (has priority)
//   load_value - value to load
//   zero       - high while the count is zero; the count holds at zero
module lock_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: digit-entry combination lock with failed-attempt lockout
// and automatic relock.
//   clk, rst     - clock (rising edge) and asynchronous active-high reset
//   digit_in     - digit value, sampled only with enter_pulse
//   enter_pulse  - accept digit / relock strobe
//   clear_pulse  - abort current entry strobe (wins over enter_pulse)
//   set_pulse    - reprogram strobe (used only with COMBO_LOCK_REPROGRAM_EN)
//   unlocked     - high only while OPEN
//   alarm        - high only while in LOCKOUT
//   disp_value   - four display nibbles
//   digit_cnt    - digits captured in the current entry
//   fail_cnt     - consecutive failed attempts
// Optional feature macro: COMBO_LOCK_REPROGRAM_EN enables the PROGRAM state
// (set_pulse in OPEN loads a new code); otherwise the code is DEFAULT_CODE.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 200_000_000,
  parameter int unsigned OPEN_CYCLES    = 500_000_000,
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        enter_pulse,
  input  logic        clear_pulse,
  input  logic        set_pulse,
  output logic        unlocked,
  output logic        alarm,
  output logic [15:0] disp_value,
  output logic [2:0]  digit_cnt,
  output logic [2:0]  fail_cnt
);

  localparam logic [2:0]  LEN3  = 3'(CODE_LEN);
  localparam logic [2:0]  MAX3  = 3'(MAX_TRIES);
  localparam logic [15:0] MASK  = code_mask(CODE_LEN);
  localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  state_t       state;
  logic [15:0]  entry_reg;
  logic [15:0]  code_reg;
  logic [15:0]  entry_shift;
  logic         match;
  logic         last_digit;
  logic         to_lockout;
  logic         tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic         tmr_zero;

  assign entry_shift = {entry_reg[11:0], digit_in};
  assign match       = ((entry_reg ^ code_reg) & MASK) == '0;
  assign last_digit  = (digit_cnt + 3'd1) == LEN3;
  assign to_lockout  = (fail_cnt + 3'd1) == MAX3;

  // The timer is loaded on the same edge that enters OPEN or LOCKOUT.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = OPEN_LOAD;
    if (state == CHECK) begin
      if (match) begin
        tmr_load = 1'b1;
      end else if (to_lockout) begin
        tmr_load  = 1'b1;
        tmr_value = LOCK_LOAD;
      end
    end
`ifdef COMBO_LOCK_REPROGRAM_EN
    if (state == PROGRAM && clear_pulse) tmr_load = 1'b1;
`endif
  end

  lock_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

`ifdef COMBO_LOCK_REPROGRAM_EN
`else
  logic unused_set;
  assign unused_set = set_pulse;
  assign code_reg   = DEFAULT_CODE;
`endif

  // Outputs are assigned alongside each transition so they always reflect
  // the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      entry_reg  <= '0;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
      disp_value <= '0;
`ifdef COMBO_LOCK_REPROGRAM_EN
      code_reg   <= DEFAULT_CODE;
`endif
    end else begin
      case (state)
        IDLE, ENTRY: begin
          if (clear_pulse) begin
            state      <= IDLE;
            entry_reg  <= '0;
            digit_cnt  <= '0;
            disp_value <= '0;
          end else if (enter_pulse) begin
            entry_reg  <= entry_shift;
            digit_cnt  <= digit_cnt + 3'd1;
            disp_value <= entry_shift;
            state      <= last_digit ? CHECK : ENTRY;
          end
        end
        CHECK: begin
          entry_reg <= '0;
          digit_cnt <= '0;
          if (match) begin
            state      <= OPEN;
            fail_cnt   <= '0;
            unlocked   <= 1'b1;
            disp_value <= DISP_OPEN;
          end else if (to_lockout) begin
            state      <= LOCKOUT;
            fail_cnt   <= fail_cnt + 3'd1;
            alarm      <= 1'b1;
            disp_value <= DISP_LOCK;
          end else begin
            state      <= IDLE;
            fail_cnt   <= fail_cnt + 3'd1;
            disp_value <= '0;
          end
        end
        OPEN: begin
          if (enter_pulse || tmr_zero) begin
            state      <= IDLE;
            unlocked   <= 1'b0;
            disp_value <= entry_reg;
          end
`ifdef COMBO_LOCK_REPROGRAM_EN
          else if (set_pulse) begin
            state      <= PROGRAM;
            unlocked   <= 1'b0;
            disp_value <= entry_reg;
          end
`endif
        end
        LOCKOUT: begin
          if (tmr_zero) begin
            state      <= IDLE;
            fail_cnt   <= '0;
            alarm      <= 1'b0;
            disp_value <= '0;
          end
        end
`ifdef COMBO_LOCK_REPROGRAM_EN
        PROGRAM: begin
          if (clear_pulse) begin
            state      <= OPEN;
            entry_reg  <= '0;
            digit_cnt  <= '0;
            unlocked   <= 1'b1;
            disp_value <= DISP_OPEN;
          end else if (enter_pulse) begin
            if (last_digit) begin
              code_reg   <= entry_shift;
              state      <= IDLE;
              entry_reg  <= '0;
              digit_cnt  <= '0;
              disp_value <= '0;
            end else begin
              entry_reg  <= entry_shift;
              digit_cnt  <= digit_cnt + 3'd1;
              disp_value <= entry_shift;
            end
          end
        end
`endif
        default: begin
          state      <= IDLE;
          entry_reg  <= '0;
          digit_cnt  <= '0;
          unlocked   <= 1'b0;
          alarm      <= 1'b0;
          disp_value <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: self-checking bench for combo_lock_ctrl with short
// timers (OPEN_CYCLES=8, LOCKOUT_CYCLES=16). Reprogramming sequences are
// included when COMBO_LOCK_REPROGRAM_EN is defined.
module tb_combo_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_in;
  logic        enter_pulse, clear_pulse, set_pulse;
  logic        unlocked, alarm;
  logic [15:0] disp_value;
  logic [2:0]  digit_cnt, fail_cnt;

  int checks = 0;
  int errors = 0;

  combo_lock_ctrl #(
    .CODE_LEN      (4),
    .MAX_TRIES     (3),
    .LOCKOUT_CYCLES(16),
    .OPEN_CYCLES   (8),
    .DEFAULT_CODE  (16'h1234)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .enter_pulse(enter_pulse),
    .clear_pulse(clear_pulse),
    .set_pulse  (set_pulse),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .disp_value (disp_value),
    .digit_cnt  (digit_cnt),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, cl, st;
    logic [3:0]  dig;
    logic        ul, al;
    logic [15:0] disp;
    logic [2:0]  dc, fc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic cl, input logic st,
                              input logic [3:0] dig, input logic ul, input logic al,
                              input logic [15:0] disp, input logic [2:0] dc,
                              input logic [2:0] fc);
    vec_t v;
    v.en = en; v.cl = cl; v.st = st; v.dig = dig;
    v.ul = ul; v.al = al; v.disp = disp; v.dc = dc; v.fc = fc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ul, input logic al,
                           input logic [15:0] disp, input logic [2:0] dc,
                           input logic [2:0] fc);
    chk({tag, ".unlocked"},   {15'd0, unlocked}, {15'd0, ul});
    chk({tag, ".alarm"},      {15'd0, alarm},    {15'd0, al});
    chk({tag, ".disp_value"}, disp_value,        disp);
    chk({tag, ".digit_cnt"},  {13'd0, digit_cnt}, {13'd0, dc});
    chk({tag, ".fail_cnt"},   {13'd0, fail_cnt},  {13'd0, fc});
  endtask

  // Drive one cycle of strobes, then sample 1 time unit after the edge.
  task automatic step(input logic en, input logic cl, input logic st, input logic [3:0] dig);
    enter_pulse = en; clear_pulse = cl; set_pulse = st; digit_in = dig;
    @(posedge clk);
    #1;
    enter_pulse = 1'b0; clear_pulse = 1'b0; set_pulse = 1'b0; digit_in = 4'h0;
  endtask

  // Enters four digits then spends the CHECK cycle.
  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) step(1'b1, 1'b0, 1'b0, code[i*4 +: 4]);
    step(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    enter_pulse = 1'b0; clear_pulse = 1'b0; set_pulse = 1'b0; digit_in = 4'h0;

    // en cl st dig   ul al disp     dc fc
    add(1,0,0,4'h1,  0,0,16'h0001, 1, 0);
    add(1,0,0,4'h2,  0,0,16'h0012, 2, 0);
    add(1,0,0,4'h3,  0,0,16'h0123, 3, 0);
    add(1,0,0,4'h4,  0,0,16'h1234, 4, 0);
    add(0,0,0,4'h0,  1,0,16'hAAAA, 0, 0); // unlocked two cycles after 4th strobe
    add(0,0,0,4'h0,  1,0,16'hAAAA, 0, 0);
    add(1,0,0,4'h0,  0,0,16'h0000, 0, 0); // enter relocks
    add(1,0,0,4'h1,  0,0,16'h0001, 1, 0);
    add(1,0,0,4'h2,  0,0,16'h0012, 2, 0);
    add(1,0,0,4'h3,  0,0,16'h0123, 3, 0);
    add(1,0,0,4'h5,  0,0,16'h1235, 4, 0);
    add(0,0,0,4'h0,  0,0,16'h0000, 0, 1); // first failure
    add(1,0,0,4'h1,  0,0,16'h0001, 1, 1);
    add(1,0,0,4'h2,  0,0,16'h0012, 2, 1);
    add(1,0,0,4'h3,  0,0,16'h0123, 3, 1);
    add(1,0,0,4'h5,  0,0,16'h1235, 4, 1);
    add(0,0,0,4'h0,  0,0,16'h0000, 0, 2); // second failure
    add(1,0,0,4'h1,  0,0,16'h0001, 1, 2);
    add(1,0,0,4'h2,  0,0,16'h0012, 2, 2);
    add(1,1,0,4'h7,  0,0,16'h0000, 0, 2); // clear beats enter, digit dropped
    add(1,1,0,4'h7,  0,0,16'h0000, 0, 2); // same in IDLE
    add(1,0,0,4'h1,  0,0,16'h0001, 1, 2);
    add(1,0,0,4'h2,  0,0,16'h0012, 2, 2);
    add(1,0,0,4'h3,  0,0,16'h0123, 3, 2);
    add(1,0,0,4'h5,  0,0,16'h1235, 4, 2);
    add(0,0,0,4'h0,  0,1,16'hFFFF, 0, 3); // third failure -> lockout
    add(1,0,0,4'h9,  0,1,16'hFFFF, 0, 3); // strobes ignored
    add(0,0,1,4'h0,  0,1,16'hFFFF, 0, 3);
    add(0,1,0,4'h0,  0,1,16'hFFFF, 0, 3);

    // Reset state
    @(posedge clk); #1;
    check_all("reset_held", 0, 0, 16'h0000, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("reset_rel", 0, 0, 16'h0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].cl, vecs[i].st, vecs[i].dig);
      check_all($sformatf("v%0d", i), vecs[i].ul, vecs[i].al, vecs[i].disp,
                vecs[i].dc, vecs[i].fc);
    end

    // Lockout duration: four alarm cycles already seen in the table.
    n = 4;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0, 4'h0);
      if (alarm) n++;
      else break;
    end
    chk("lockout_cycles", 16'(n), 16'd16);
    check_all("after_lockout", 0, 0, 16'h0000, 0, 0);

    // Open timeout
    enter_code(16'h1234);
    check_all("open_timeout_start", 1, 0, 16'hAAAA, 0, 0);
    n = 1;
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 0, 4'h0);
      if (unlocked) n++;
      else break;
    end
    chk("open_cycles", 16'(n), 16'd8);
    check_all("after_timeout", 0, 0, 16'h0000, 0, 0);

    // Enter in OPEN relocks on the next edge
    enter_code(16'h1234);
    step(0, 0, 0, 4'h0);
    check_all("open_hold", 1, 0, 16'hAAAA, 0, 0);
    step(1, 0, 0, 4'h3);
    check_all("open_enter", 0, 0, 16'h0000, 0, 0);

`ifdef COMBO_LOCK_REPROGRAM_EN
    enter_code(16'h1234);
    check_all("prog_open", 1, 0, 16'hAAAA, 0, 0);
    step(0, 0, 1, 4'h0);
    check_all("prog_enter", 0, 0, 16'h0000, 0, 0);
    step(1, 0, 0, 4'h9);
    step(1, 0, 0, 4'h8);
    step(1, 0, 0, 4'h7);
    check_all("prog_digits", 0, 0, 16'h0987, 3, 0);
    step(1, 0, 0, 4'h6);
    check_all("prog_done", 0, 0, 16'h0000, 0, 0);
    enter_code(16'h1234);
    check_all("prog_old_code", 0, 0, 16'h0000, 0, 1);
    enter_code(16'h9876);
    check_all("prog_new_code", 1, 0, 16'hAAAA, 0, 0);
    step(1, 0, 0, 4'h0);
`endif

    // Asynchronous reset during lockout
    enter_code(16'h1235);
    enter_code(16'h1235);
    enter_code(16'h1235);
    check_all("rst_lockout_pre", 0, 1, 16'hFFFF, 0, 3);
    step(0, 0, 0, 4'h0);
    rst = 1'b1;
    #1;
    check_all("rst_async", 0, 0, 16'h0000, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("rst_after_edge", 0, 0, 16'h0000, 0, 0);
    enter_code(16'h1234);
    check_all("rst_default_code", 1, 0, 16'hAAAA, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
